event_replay_scheduler: RTL and testbench

EVENT_REPLAY_SCHEDULER -- requirements
Module: event_replay_scheduler

---
 rtl/event_replay_scheduler.sv | 169 ++++++++++++++++
 tb/tb_event_replay_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/event_replay_scheduler.sv
// Event replay scheduler: buffers timestamped events in arrival order and
// releases the head event once the wallclock has reached its timestamp,
// flagging releases that happen more than LATE_TH cycles late.
module event_replay_scheduler #(
  parameter int unsigned SIZE    = 32,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATE_TH = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [SIZE-1:0]            now_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [SIZE-1:0]            in_ts_i,
  input  logic [DATA_W-1:0]          in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [SIZE-1:0]            out_ts_o,
  output logic                       out_late_o,
  output logic [15:0]                late_cnt_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] FullLvl = LvlW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StPresent} state_e;

  // Pending-event storage; only the pointers and occupancy need a reset.
  logic [SIZE-1:0]   ts_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;

  state_e            state_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [SIZE-1:0]   out_ts_q;
  logic              out_late_q;
  logic [15:0]       late_cnt_q;

  logic [SIZE-1:0]   head_ts;
  logic [DATA_W-1:0] head_data;
  logic [SIZE-1:0]   head_diff;
  logic              head_due;
  logic              head_late;
  logic              push;
  logic              pop;
  logic              ready;

  // Head timing: a modular difference with a clear sign bit means the
  // timestamp has been reached, which stays correct across wallclock wrap.
  always_comb begin
    head_ts   = ts_mem_q[rd_ptr_q];
    head_data = data_mem_q[rd_ptr_q];
    head_diff = now_i - head_ts;
    head_due  = ~head_diff[SIZE-1];
    head_late = head_due && (head_diff > SIZE'(LATE_TH));
  end

  // Handshake decode; readiness depends on registered occupancy only.
  always_comb begin
    ready = (level_q != FullLvl);
    push  = in_valid_i && ready;
    // Popping only happens on the WAIT->PRESENT edge, so at most one event
    // is ever held in the output register.
    pop   = (state_q == StWait) && head_due;
  end

  // FIFO pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO payload writes.
  always_ff @(posedge clk_i) begin
    if (push) begin
      ts_mem_q[wr_ptr_q]   <= in_ts_i;
      data_mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Release FSM with registered output event and late counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ts_q    <= '0;
      out_late_q  <= 1'b0;
      late_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (level_q != '0) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (head_due) begin
            state_q     <= StPresent;
            out_valid_q <= 1'b1;
            out_data_q  <= head_data;
            out_ts_q    <= head_ts;
            out_late_q  <= head_late;
            if (head_late && (late_cnt_q != 16'hFFFF)) begin
              late_cnt_q <= late_cnt_q + 16'd1;
            end
          end
        end
        StPresent: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            // A push on the handshake edge counts towards non-empty.
            if ((level_q != '0) || push) begin
              state_q <= StWait;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = ready;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ts_o    = out_ts_q;
  assign out_late_o  = out_late_q;
  assign late_cnt_o  = late_cnt_q;
  assign level_o     = level_q;

endmodule

// File: tb/tb_event_replay_scheduler.sv
// Directed bench for event_replay_scheduler with hand-computed expectations.
module tb_event_replay_scheduler;

  localparam int unsigned SIZE    = 32;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LATE_TH = 8;

  logic              clk_i;
  logic              reset_i;
  logic [SIZE-1:0]   now_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [SIZE-1:0]   in_ts_i;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [SIZE-1:0]   out_ts_o;
  logic              out_late_o;
  logic [15:0]       late_cnt_o;
  logic [2:0]        level_o;

  int unsigned total;
  int unsigned passed;
  int          lvl_exp [4] = '{1, 2, 2, 3};

  event_replay_scheduler #(
    .SIZE    (SIZE),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .LATE_TH (LATE_TH)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .now_i       (now_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_ts_i     (in_ts_i),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_ts_o    (out_ts_o),
    .out_late_o  (out_late_o),
    .late_cnt_o  (late_cnt_o),
    .level_o     (level_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock; the wallclock advances right after each edge.
  task automatic step();
    @(posedge clk_i);
    #1;
    now_i = now_i + 32'd1;
  endtask

  task automatic push(input logic [SIZE-1:0] ts, input logic [DATA_W-1:0] data);
    in_valid_i = 1'b1;
    in_ts_i    = ts;
    in_data_i  = data;
    step();
    in_valid_i = 1'b0;
  endtask

  task automatic handshake();
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
  endtask

  initial begin
    total       = 0;
    passed      = 0;
    reset_i     = 1'b1;
    now_i       = '0;
    in_valid_i  = 1'b0;
    in_ts_i     = '0;
    in_data_i   = '0;
    out_ready_i = 1'b0;

    // Reset state
    step();
    step();
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_level", 64'(level_o), 64'd0);
    check("rst_ready", 64'(in_ready_o), 64'd1);
    check("rst_data", 64'(out_data_o), 64'd0);
    check("rst_ts", 64'(out_ts_o), 64'd0);
    check("rst_late", 64'(out_late_o), 64'd0);
    check("rst_cnt", 64'(late_cnt_o), 64'd0);
    reset_i = 1'b0;
    step();

    // Single future event: released on the edge sampling now=105
    now_i = 32'd100;
    push(32'd105, 16'hA5A5);
    check("t1_level", 64'(level_o), 64'd1);
    repeat (4) step();
    check("t1_not_early", 64'(out_valid_o), 64'd0);
    step();
    check("t1_valid", 64'(out_valid_o), 64'd1);
    check("t1_data", 64'(out_data_o), 64'hA5A5);
    check("t1_ts", 64'(out_ts_o), 64'd105);
    check("t1_late", 64'(out_late_o), 64'd0);
    check("t1_cnt", 64'(late_cnt_o), 64'd0);
    check("t1_level0", 64'(level_o), 64'd0);
    handshake();
    check("t1_idle", 64'(out_valid_o), 64'd0);

    // Late event: presented two cycles after acceptance
    now_i = 32'd200;
    push(32'd150, 16'h1111);
    step();
    check("t2_wait", 64'(out_valid_o), 64'd0);
    step();
    check("t2_valid", 64'(out_valid_o), 64'd1);
    check("t2_data", 64'(out_data_o), 64'h1111);
    check("t2_ts", 64'(out_ts_o), 64'd150);
    check("t2_late", 64'(out_late_o), 64'd1);
    check("t2_cnt", 64'(late_cnt_o), 64'd1);
    handshake();

    // Threshold boundary: diff == LATE_TH is on time, LATE_TH+1 is late
    now_i = 32'd300;
    push(32'd294, 16'h2222);
    step();
    step();
    check("th_eq_valid", 64'(out_valid_o), 64'd1);
    check("th_eq_late", 64'(out_late_o), 64'd0);
    check("th_eq_cnt", 64'(late_cnt_o), 64'd1);
    handshake();
    now_i = 32'd400;
    push(32'd393, 16'h3333);
    step();
    step();
    check("th_gt_late", 64'(out_late_o), 64'd1);
    check("th_gt_cnt", 64'(late_cnt_o), 64'd2);
    handshake();

    // Wallclock wrap: ts=2 pushed at now=FFFFFFFE waits until now=2
    now_i = 32'hFFFF_FFFE;
    push(32'd2, 16'h4444);
    repeat (3) step();
    check("wrap_not_early", 64'(out_valid_o), 64'd0);
    step();
    check("wrap_valid", 64'(out_valid_o), 64'd1);
    check("wrap_ts", 64'(out_ts_o), 64'd2);
    check("wrap_late", 64'(out_late_o), 64'd0);
    handshake();

    // Fill under backpressure, ignored overflow offer, in-order drain
    now_i = 32'd1000;
    for (int k = 0; k < 4; k++) begin
      push(32'(1000 + 2 * k), 16'(16'hD000 + k));
      check("full_level", 64'(level_o), 64'(lvl_exp[k]));
    end
    check("full_first", 64'(out_valid_o), 64'd1);
    check("full_first_data", 64'(out_data_o), 64'hD000);
    check("full_ready3", 64'(in_ready_o), 64'd1);
    push(32'd1008, 16'hD004);
    check("full_level4", 64'(level_o), 64'd4);
    check("full_ready0", 64'(in_ready_o), 64'd0);
    push(32'd0, 16'hDEAD);
    check("ovf_level", 64'(level_o), 64'd4);
    check("ovf_data", 64'(out_data_o), 64'hD000);
    out_ready_i = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      check("drain_gap", 64'(out_valid_o), 64'd0);
      step();
      check("drain_valid", 64'(out_valid_o), 64'd1);
      check("drain_data", 64'(out_data_o), 64'(16'hD000 + k));
      check("drain_level", 64'(level_o), 64'(4 - k));
      check("drain_late", 64'(out_late_o), 64'd0);
    end
    step();
    check("drain_empty", 64'(out_valid_o), 64'd0);
    out_ready_i = 1'b0;
    step();
    check("drain_no_ovf", 64'(out_valid_o), 64'd0);
    check("drain_cnt", 64'(late_cnt_o), 64'd2);

    // Stall stability, then next event two cycles after the handshake
    now_i = 32'd2000;
    push(32'd1995, 16'hBEEF);
    push(32'd2000, 16'hCAFE);
    step();
    check("stall_valid", 64'(out_valid_o), 64'd1);
    check("stall_level", 64'(level_o), 64'd1);
    for (int k = 0; k < 10; k++) begin
      step();
      check("stall_hold_valid", 64'(out_valid_o), 64'd1);
      check("stall_hold_data", 64'(out_data_o), 64'hBEEF);
      check("stall_hold_ts", 64'(out_ts_o), 64'd1995);
      check("stall_hold_late", 64'(out_late_o), 64'd0);
    end
    handshake();
    check("stall_gap", 64'(out_valid_o), 64'd0);
    step();
    check("stall_next_valid", 64'(out_valid_o), 64'd1);
    check("stall_next_data", 64'(out_data_o), 64'hCAFE);
    check("stall_next_ts", 64'(out_ts_o), 64'd2000);
    check("stall_next_late", 64'(out_late_o), 64'd1);
    check("stall_next_cnt", 64'(late_cnt_o), 64'd3);
    handshake();

    // Asynchronous reset with three pending and one presented event
    now_i = 32'd3000;
    for (int k = 0; k < 4; k++) begin
      push(32'd3000, 16'(16'hE000 + k));
    end
    check("mid_level", 64'(level_o), 64'd3);
    check("mid_valid", 64'(out_valid_o), 64'd1);
    reset_i = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid_o), 64'd0);
    check("arst_level", 64'(level_o), 64'd0);
    check("arst_ready", 64'(in_ready_o), 64'd1);
    check("arst_data", 64'(out_data_o), 64'd0);
    check("arst_ts", 64'(out_ts_o), 64'd0);
    check("arst_late", 64'(out_late_o), 64'd0);
    check("arst_cnt", 64'(late_cnt_o), 64'd0);
    reset_i = 1'b0;
    step();
    check("post_rst_level", 64'(level_o), 64'd0);
    check("post_rst_valid", 64'(out_valid_o), 64'd0);
    push(now_i, 16'h5555);
    repeat (2) step();
    check("post_rst_data", 64'(out_data_o), 64'h5555);
    check("post_rst_valid2", 64'(out_valid_o), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
